// File: rtl/encoder_pkg.sv
// encoder_pkg: FSM state type, button code constants and encode helpers for encoder_4_2.
// With ENCODER_DEBOUNCE_EN defined the state type carries all four debounce states.
// Without it, only IDLE and PRESSED exist.
package encoder_pkg;
`ifdef ENCODER_DEBOUNCE_EN
    typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} state_t;
`else
    typedef enum logic {IDLE, PRESSED} state_t;
`endif
    localparam logic [1:0] CODE_B3 = 2'd0;
    localparam logic [1:0] CODE_B2 = 2'd1;
    localparam logic [1:0] CODE_B1 = 2'd2;
    localparam logic [1:0] CODE_B0 = 2'd3;
    // btn[3] wins when several lines are set
    function automatic logic [1:0] enc_code(input logic [3:0] b);
        return b[3] ? CODE_B3 : b[2] ? CODE_B2 : b[1] ? CODE_B1 : CODE_B0;
    endfunction
    // clearing the lowest set bit leaves something only if two or more were set
    function automatic logic is_multi(input logic [3:0] b);
        return (b & (b - 4'd1)) != 4'd0;
    endfunction
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: 1-bit two-flop synchronizer with async active-low reset.
//   clk   : destination clock
//   rst_n : async active-low reset, clears both flops
//   d_i   : asynchronous input
//   q_o   : synchronized output, two clk edges after d_i
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);
    logic meta_q, sync_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end
    assign q_o = sync_q;
endmodule

// File: rtl/encoder_4_2.sv
// encoder_4_2: debounced 4-to-2 priority button encoder with press strobe.
//   clk       : single clock, all state changes on its rising edge
//   rst_n     : async active-low reset
//   btn[3:0]  : asynchronous active-high button lines
//   code[1:0] : index of the accepted button (btn[3]->0 .. btn[0]->3)
//   valid     : high while an accepted press is held
//   press_stb : one-cycle pulse per accepted press
//   multi     : more than one line was set when the press was accepted
// ENCODER_DEBOUNCE_EN enables the DEBOUNCE_CYCLES counter with its DEBOUNCE and RELEASE states.
// Without it, presses are accepted and released on the first synchronized sample.
module encoder_4_2
    import encoder_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] btn,
    output logic [1:0] code,
    output logic       valid,
    output logic       press_stb,
    output logic       multi
);
    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 65535) begin : g_bad_param
        $error("encoder_4_2: DEBOUNCE_CYCLES out of range 2..65535");
    end

    logic [3:0] sample;
    for (genvar i = 0; i < 4; i++) begin : g_sync
        sync_2ff u_sync (.clk(clk), .rst_n(rst_n), .d_i(btn[i]), .q_o(sample[i]));
    end

    state_t     state_q;
    logic [1:0] code_q;
    logic       valid_q, stb_q, multi_q;

`ifdef ENCODER_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
    logic [3:0]    cap_q;
    logic [CW-1:0] cnt_q;
    // counter only advances while below LAST, so it never wraps
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cap_q   <= '0;
            cnt_q   <= '0;
            code_q  <= '0;
            valid_q <= 1'b0;
            stb_q   <= 1'b0;
            multi_q <= 1'b0;
        end else begin
            stb_q <= 1'b0;
            case (state_q)
                IDLE: if (sample != 4'd0) begin
                    state_q <= DEBOUNCE;
                    cap_q   <= sample;
                    cnt_q   <= '0;
                end
                DEBOUNCE: if (sample == 4'd0) begin
                    state_q <= IDLE;
                end else if (sample != cap_q) begin
                    cap_q <= sample;
                    cnt_q <= '0;
                end else if (cnt_q == LAST) begin
                    state_q <= PRESSED;
                    code_q  <= enc_code(cap_q);
                    valid_q <= 1'b1;
                    stb_q   <= 1'b1;
                    multi_q <= is_multi(cap_q);
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
                // a changed nonzero pattern while pressed is deliberately ignored
                PRESSED: if (sample == 4'd0) begin
                    state_q <= RELEASE;
                    cnt_q   <= '0;
                end
                RELEASE: if (sample != 4'd0) begin
                    state_q <= PRESSED;
                end else if (cnt_q == LAST) begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            code_q  <= '0;
            valid_q <= 1'b0;
            stb_q   <= 1'b0;
            multi_q <= 1'b0;
        end else begin
            stb_q <= 1'b0;
            case (state_q)
                IDLE: if (sample != 4'd0) begin
                    state_q <= PRESSED;
                    code_q  <= enc_code(sample);
                    valid_q <= 1'b1;
                    stb_q   <= 1'b1;
                    multi_q <= is_multi(sample);
                end
                PRESSED: if (sample == 4'd0) begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
`endif

    assign code      = code_q;
    assign valid     = valid_q;
    assign press_stb = stb_q;
    assign multi     = multi_q;
endmodule
